// File: rtl/fcel_cfg_loader.sv
// Serial configuration loader for the fcel cell: hunts for a sync word,
// shifts in a CRC-8 protected frame and commits it to ctrs atomically.
module fcel_cfg_loader #(
  parameter int          CFG_W = 124,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_ready,
  output logic [CFG_W-1:0] ctrs,
  output logic             ctrs_valid,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err
);

  localparam int CW = $clog2(CFG_W);

  typedef enum logic [1:0] {
    HUNT,
    LOAD,
    CRC,
    VERIFY
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       sync_sr;
  logic [7:0]       crc;
  logic [7:0]       rx_crc;
  logic [7:0]       crc_nxt;
  logic [CW-1:0]    cnt;
  logic [CFG_W-1:0] shadow;
  logic             acc;
  logic             sync_hit;
  logic             last_data;
  logic             last_crc;
  logic             fb;

  assign acc       = cfg_valid & cfg_ready;
  assign sync_hit  = ({sync_sr[6:0], cfg_bit} == SYNC);
  assign last_data = (cnt == CW'(CFG_W - 1));
  assign last_crc  = (cnt == CW'(7));
  assign fb        = crc[7] ^ cfg_bit;
  assign crc_nxt   = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      HUNT:   if (acc && sync_hit)  state_nxt = LOAD;
      LOAD:   if (acc && last_data) state_nxt = CRC;
      CRC:    if (acc && last_crc)  state_nxt = VERIFY;
      VERIFY: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    cfg_ready = (state != VERIFY);
    cfg_busy  = (state != HUNT);
  end

  // Shadow and CRC only reach ctrs through the VERIFY commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_sr    <= '0;
      crc        <= '0;
      rx_crc     <= '0;
      cnt        <= '0;
      shadow     <= '0;
      ctrs       <= '0;
      ctrs_valid <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      unique case (state)
        HUNT: begin
          if (acc) begin
            sync_sr <= {sync_sr[6:0], cfg_bit};
            if (sync_hit) begin
              cnt <= '0;
              crc <= '0;
            end
          end
        end
        LOAD: begin
          if (acc) begin
            shadow <= {shadow[CFG_W-2:0], cfg_bit};
            crc    <= crc_nxt;
            cnt    <= last_data ? '0 : cnt + 1'b1;
          end
        end
        CRC: begin
          if (acc) begin
            rx_crc <= {rx_crc[6:0], cfg_bit};
            cnt    <= cnt + 1'b1;
          end
        end
        VERIFY: begin
          sync_sr <= '0;
          if (rx_crc == crc) begin
            ctrs       <= shadow;
            ctrs_valid <= 1'b1;
            cfg_done   <= 1'b1;
          end else begin
            cfg_err <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fcel_cfg_loader.sv
// Directed bench for fcel_cfg_loader: framing, CRC commit/reject,
// sync hunting, stalls and asynchronous reset mid-frame.
module tb_fcel_cfg_loader;

  localparam int         W      = 124;
  localparam logic [7:0] SYNC_W = 8'hA5;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid;
  logic         cfg_bit;
  logic         cfg_ready;
  logic [W-1:0] ctrs;
  logic         ctrs_valid;
  logic         cfg_busy;
  logic         cfg_done;
  logic         cfg_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_n = 0;
  int err_n = 0;
  int nrdy_n = 0;
  int busy_n = 0;
  int done_cyc = 0;

  fcel_cfg_loader #(.CFG_W(W), .SYNC(SYNC_W)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready),
    .ctrs(ctrs),
    .ctrs_valid(ctrs_valid),
    .cfg_busy(cfg_busy),
    .cfg_done(cfg_done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cfg_done) begin
      done_n   = done_n + 1;
      done_cyc = cyc;
    end
    if (cfg_err)    err_n  = err_n + 1;
    if (!cfg_ready) nrdy_n = nrdy_n + 1;
    if (cfg_busy)   busy_n = busy_n + 1;
  end

  function automatic logic [7:0] crc_of(input logic [W-1:0] d);
    logic [7:0] c;
    logic       f;
    c = 8'h00;
    for (int i = W - 1; i >= 0; i--) begin
      f = c[7] ^ d[i];
      c = {c[6:0], 1'b0} ^ (f ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic idle(input int n);
    cfg_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input bit gap);
    int n;
    if (gap) begin
      n = $urandom_range(0, 3);
      idle(n);
    end
    cfg_valid = 1'b1;
    cfg_bit   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic [7:0] c,
                            input bit gap);
    for (int i = 7; i >= 0; i--) send_bit(SYNC_W[i], gap);
    for (int i = W - 1; i >= 0; i--) send_bit(d[i], gap);
    for (int i = 7; i >= 0; i--) send_bit(c[i], gap);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    int d0;
    int e0;
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ctrs !== '0) begin
      errors++;
      $display("FAIL reset_ctrs got=%h exp=0", ctrs);
    end
    checks++;
    if ({ctrs_valid, cfg_ready, cfg_busy, cfg_done, cfg_err} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=01000",
               {ctrs_valid, cfg_ready, cfg_busy, cfg_done, cfg_err});
    end
    rst = 1'b0;
    d0 = done_n;
    e0 = err_n;
    idle(20);
    checks++;
    if (ctrs !== '0 || ctrs_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ctrs got=%h/%b exp=0/0", ctrs, ctrs_valid);
    end
    checks++;
    if (cfg_ready !== 1'b1 || cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready_busy got=%b%b exp=10", cfg_ready, cfg_busy);
    end
    checks++;
    if (done_n - d0 != 0 || err_n - e0 != 0) begin
      errors++;
      $display("FAIL idle_pulses got=%0d/%0d exp=0/0", done_n - d0, err_n - e0);
    end
  endtask

  task automatic test_zero_frame;
    int d0;
    int e0;
    int r0;
    int start;
    d0 = done_n;
    e0 = err_n;
    r0 = nrdy_n;
    start = cyc;
    send_frame('0, 8'h00, 1'b0);
    idle(4);
    checks++;
    if (nrdy_n - r0 != 1) begin
      errors++;
      $display("FAIL zero_ready_low got=%0d exp=1", nrdy_n - r0);
    end
    checks++;
    if (done_n - d0 != 1 || err_n - e0 != 0) begin
      errors++;
      $display("FAIL zero_pulses got=%0d/%0d exp=1/0", done_n - d0, err_n - e0);
    end
    checks++;
    if (ctrs !== '0 || ctrs_valid !== 1'b1) begin
      errors++;
      $display("FAIL zero_ctrs got=%h/%b exp=0/1", ctrs, ctrs_valid);
    end
    checks++;
    if (done_cyc - start != 141) begin
      errors++;
      $display("FAIL zero_latency got=%0d exp=141", done_cyc - start);
    end
  endtask

  task automatic test_good_999(input bit gap);
    logic [W-1:0] v;
    int d0;
    v = W'(999);
    d0 = done_n;
    send_frame(v, crc_of(v), gap);
    idle(4);
    checks++;
    if (ctrs !== v || ctrs_valid !== 1'b1) begin
      errors++;
      $display("FAIL good999_ctrs gap=%0d got=%h exp=%h", gap, ctrs, v);
    end
    checks++;
    if (done_n - d0 != 1) begin
      errors++;
      $display("FAIL good999_done gap=%0d got=%0d exp=1", gap, done_n - d0);
    end
  endtask

  task automatic test_corrupt_crc;
    int d0;
    int e0;
    d0 = done_n;
    e0 = err_n;
    send_frame('0, 8'h01, 1'b0);
    idle(4);
    checks++;
    if (err_n - e0 != 1 || done_n - d0 != 0) begin
      errors++;
      $display("FAIL corrupt_pulses got=%0d/%0d exp=1/0", err_n - e0, done_n - d0);
    end
    checks++;
    if (ctrs !== W'(999) || ctrs_valid !== 1'b1) begin
      errors++;
      $display("FAIL corrupt_ctrs got=%h/%b exp=3e7/1", ctrs, ctrs_valid);
    end
  endtask

  task automatic test_sync_hunt;
    logic [7:0]   a4;
    logic [7:0]   g;
    logic [W-1:0] v;
    int b0;
    int d0;
    a4 = 8'hA4;
    g  = 8'b1101_0010;
    v  = W'(12'h5A5);
    b0 = busy_n;
    d0 = done_n;
    for (int i = 7; i >= 0; i--) send_bit(a4[i], 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(g[i], 1'b0);
    checks++;
    if (busy_n - b0 != 0 || cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL hunt_no_busy got=%0d exp=0", busy_n - b0);
    end
    // garbage tail 1010010 followed by a 1 would itself match, so pad a 0
    send_bit(1'b0, 1'b0);
    send_frame(v, crc_of(v), 1'b0);
    idle(4);
    checks++;
    if (ctrs !== v || done_n - d0 != 1) begin
      errors++;
      $display("FAIL hunt_commit got=%h/%0d exp=%h/1", ctrs, done_n - d0, v);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] v;
    int d0;
    v = W'(999);
    for (int i = 7; i >= 0; i--) send_bit(SYNC_W[i], 1'b0);
    for (int i = W - 1; i >= W - 61; i--) send_bit(v[i], 1'b0);
    checks++;
    if (ctrs !== W'(12'h5A5) || cfg_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_stable got=%h/%b exp=5a5/1", ctrs, cfg_busy);
    end
    d0 = done_n;
    rst = 1'b1;
    #1;
    checks++;
    if (ctrs !== '0 || ctrs_valid !== 1'b0 || cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_async got=%h/%b/%b exp=0/0/0", ctrs, ctrs_valid, cfg_busy);
    end
    cfg_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = W - 62; i >= 0; i--) send_bit(v[i], 1'b0);
    idle(20);
    checks++;
    if (done_n - d0 != 0 || ctrs !== '0) begin
      errors++;
      $display("FAIL mid_no_done got=%0d/%h exp=0/0", done_n - d0, ctrs);
    end
    send_frame(v, crc_of(v), 1'b0);
    idle(4);
    checks++;
    if (ctrs !== v || ctrs_valid !== 1'b1 || done_n - d0 != 1) begin
      errors++;
      $display("FAIL mid_recover got=%h/%b/%0d exp=3e7/1/1", ctrs, ctrs_valid,
               done_n - d0);
    end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_good_999(1'b0);
    test_good_999(1'b1);
    test_corrupt_crc();
    test_sync_hunt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fcel_cfg_loader.md
# fcel_cfg_loader

Serial configuration loader for the `fcel` fabric cell: receives a framed, CRC-protected bitstream one bit per cycle, assembles it into a shadow register, and commits it atomically to the cell's `ctrs` configuration bus only after the frame checks clean. It sits between the chip-level configuration port and one `fcel` instance. It is the writer side of the `ctrs` interface that `fcel` consumes.

## Interface
- `CFG_W`, 124: configuration width; equals `fcel` `ctrs` width.
- `SYNC`, 8'hA5: frame sync word, received MSB first.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  `cfg_bit` is valid this cycle.
- `cfg_bit`  in  1  serial configuration data.
- `cfg_ready`  out  1  loader accepts a bit this cycle. A bit is accepted when `cfg_valid & cfg_ready`.
- `ctrs`  out  CFG_W  committed configuration to `fcel`.
- `ctrs_valid`  out  1  set by the first successful commit; stays set until reset.
- `cfg_busy`  out  1  high in LOAD, CRC and VERIFY.
- `cfg_done`  out  1  one-cycle pulse on successful commit.
- `cfg_err`  out  1  one-cycle pulse on CRC mismatch.

## Operation
- **Reset values:**
  - `ctrs` = 0, `ctrs_valid` = 0, `cfg_busy` = 0, `cfg_done` = 0, `cfg_err` = 0.
  - `cfg_ready` = 1.
  - State = HUNT, sync shifter = 0, bit counter = 0, CRC = 0.
- **`cfg_ready`** = (state != VERIFY).
- **States:**
  - HUNT: each accepted bit is shifted into an 8-bit sync shifter, new bit at the LSB. When {shifter[6:0], cfg_bit} == SYNC on an accepted bit, go to LOAD, clear the counter and clear the CRC.
  - LOAD: each accepted bit shifts into the shadow register at the LSB. The first data bit therefore ends in shadow[CFG_W-1] (MSB-first). The CRC is updated with the bit and the counter increments. The accepted bit with counter == CFG_W-1 moves the state to CRC and clears the counter.
  - CRC: 8 accepted bits shift MSB-first into `rx_crc`. The 8th bit moves the state to VERIFY.
  - VERIFY: one cycle with no bit accepted.
    - If `rx_crc` == computed CRC: `ctrs` <= shadow, `ctrs_valid` <= 1, `cfg_done` pulses.
    - Otherwise: `cfg_err` pulses and `ctrs` is unchanged.
    - In both cases the next state is HUNT with the sync shifter cleared.
- **CRC-8:**
  - Polynomial 0x07, initial value 0x00, no reflection, no final XOR.
  - Computed over the CFG_W data bits only; sync and CRC bits are excluded.
  - Per bit: fb = crc[7] ^ bit; crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00).
- **Counter:** 7 bits for CFG_W = 124. Width is $clog2(CFG_W); no wrap is reachable.
- **Stalls:** `cfg_valid` low freezes all state indefinitely. There is no timeout.
- **`ctrs` stability:** `ctrs` changes only on a VERIFY with a matching CRC. A partial or corrupt frame never disturbs the running cell.
- **No in-band abort:** a sync pattern appearing inside LOAD or CRC data is treated as data. Only `rst` aborts a frame.

## Timing
- Bit accepted at edge N: state, shadow and CRC update at edge N.
- The 8th CRC bit accepted at edge N puts the state in VERIFY for the cycle after N.
- At edge N+1:
  - `ctrs` and `ctrs_valid` update.
  - `cfg_done` or `cfg_err` is high for exactly the cycle following N+1.
  - State returns to HUNT and `cfg_ready` is 1 again.
- `cfg_ready` is low for exactly one cycle per frame.
- Minimum frame with back-to-back valid bits: 8 + CFG_W + 8 = 140 accepted bits plus 1 VERIFY cycle = 141 cycles.
- A sync match sets LOAD at the same edge. The next accepted bit is data bit 0.
- `rst` asserted at any time, including mid-LOAD or in VERIFY:
  - All outputs take their reset values immediately (asynchronously).
  - A pending `cfg_done`/`cfg_err` is cancelled.
  - The shadow register is discarded.
- **Frame accepted at edge N+1:** after deassertion the first edge already samples in HUNT.

## Test plan
- **Reset values:** hold `rst`, then release → `ctrs` = 0, `ctrs_valid` = 0, `cfg_ready` = 1, no pulses; 20 idle cycles produce no change.
- **All-zero frame:** sync 8'hA5, 124 zeros, CRC 8'h00 back-to-back.
  - `cfg_ready` low for 1 cycle; `cfg_done` pulses once; `ctrs` = 0; `ctrs_valid` = 1.
  - Done pulse appears 141 cycles after the first sync bit.
- **Good frame, value 999:** sync, data `ctrs` = 124'd999 MSB-first, CRC from bench reference model.
  - `ctrs` = 999 after commit; `cfg_done` pulses.
  - Repeating the frame with random `cfg_valid` gaps gives the same result.
- **Corrupt CRC:** after loading 999, send an all-zero frame with CRC 8'h01 → `cfg_err` pulses once; `ctrs` stays 999; `ctrs_valid` stays 1.
- **Sync hunting:** send garbage bits 8'b1101_0010, then 8'hA5, then a valid frame → the frame is found and committed. A lone 8'hA4 produces no busy.
- **Reset mid-operation:** assert `rst` after data bit 60 of a 999 frame → `ctrs` = 0 immediately, `cfg_done` never pulses. The next complete frame commits normally.
